// File: rtl/spi_master_pkg.sv
// Shared types for the multi-device SPI master.
// FSM state encoding and SPI mode constants ({cpol,cpha}).
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period strobe generator for the SPI master.
// Ports: clk, reset, restart (reload), load (reload value), tick (strobe).
module spi_tick_gen
    import spi_master_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic [DIV_W-1:0] load,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Reload on restart or on reaching zero, so a tick
    // fires every (load+1) cycles after a restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || cnt == '0) begin
            cnt <= load;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: word width, CPOL/CPHA, SCLK divider, NUM_CS selects.
// Ports: clk/reset, clk_div, cpol, cpha, cs_sel, tx_data, start -> busy, done,
// rx_data; pins sclk, mosi, miso, cs_n (all outputs registered).
module spi_master_multi
    import spi_master_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_CS   = 2,
    parameter int DIV_W    = 16,
    parameter int CS_SETUP = 1,
    parameter int CS_HOLD  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DIV_W-1:0]       clk_div,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic [(NUM_CS > 1 ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    input  logic [DATA_W-1:0]      tx_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [NUM_CS-1:0]      cs_n
);

    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam int PH_MAX = max2(CS_SETUP, CS_HOLD);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t state_q;
    state_t state_d;

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_n;
    logic [PH_W-1:0]   ph_cnt;
    logic [DIV_W-1:0]  div_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [NUM_CS-1:0] cs_dec;

    logic accept;
    logic tick;
    logic lead;
    logic last_edge;
    logic setup_end;
    logic hold_end;

    assign accept    = (state_q == IDLE) && start;
    assign edge_n    = edge_cnt + 1'b1;
    assign lead      = edge_n[0];
    assign last_edge = (edge_n == EDGE_W'(2 * DATA_W));
    assign setup_end = tick && (ph_cnt == PH_W'(CS_SETUP - 1));
    assign hold_end  = tick && (ph_cnt == PH_W'(CS_HOLD - 1));

    // An out-of-range select leaves every chip select high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    // The divider value is taken straight from the port on the
    // accept cycle, since div_q only catches it on that edge.
    spi_tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(accept),
        .load   (accept ? clk_div : div_q),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = SETUP;
            SETUP: if (setup_end) state_d = SHIFT;
            SHIFT: if (tick && last_edge) state_d = HOLD;
            HOLD:  if (hold_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= '1;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            ph_cnt   <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    sclk <= cpol;
                    if (start) begin
                        busy     <= 1'b1;
                        cs_n     <= cs_dec;
                        tx_sr    <= tx_data;
                        div_q    <= clk_div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        edge_cnt <= '0;
                        ph_cnt   <= '0;
                        // CPHA=0 needs the MSB on the wire before edge 1.
                        if (!cpha) begin
                            mosi <= tx_data[DATA_W-1];
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        ph_cnt <= setup_end ? '0 : ph_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_n;
                        if (lead) begin
                            if (cpha_q) begin
                                mosi  <= tx_sr[DATA_W-1];
                                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                            end else begin
                                rx_sr <= {rx_sr[DATA_W-2:0], miso};
                            end
                        end else begin
                            if (cpha_q) begin
                                rx_sr <= {rx_sr[DATA_W-2:0], miso};
                            end else if (!last_edge) begin
                                mosi  <= tx_sr[DATA_W-2];
                                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                HOLD: begin
                    sclk <= cpol_q;
                    if (tick) begin
                        if (hold_end) begin
                            ph_cnt  <= '0;
                            cs_n    <= '1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rx_data <= rx_sr;
                        end else begin
                            ph_cnt <= ph_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
